// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the RV32I multi-cycle sequencer: FSM states,
// major opcodes and the writeback / next-PC mux encodings.
`timescale 1ns/1ps
package rv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;
    localparam logic [1:0] WB_IMM  = 2'b11;

    localparam logic [1:0] PCSEL_PC4    = 2'b00;
    localparam logic [1:0] PCSEL_BRANCH = 2'b01;
    localparam logic [1:0] PCSEL_JALR   = 2'b10;

    // SYSTEM counts as legal here; it halts cleanly rather than with an error.
    function automatic logic opcode_legal(input logic [6:0] opc);
        logic legal;
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
            OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, OPC_SYSTEM: legal = 1'b1;
            default:                                            legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the sequencer and the datapath / shared memory port.
`timescale 1ns/1ps
interface multicycle_ctrl_if;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        branch_taken;
    logic        mem_ready;

    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        alu_a_pc;
    logic        alu_b_imm;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic        halted;
    logic        err;
    logic [31:0] instret;

    modport master (
        input  opcode, funct3, branch_taken, mem_ready,
        output mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel,
               alu_a_pc, alu_b_imm, rf_we, wb_sel, halted, err, instret
    );

    modport slave (
        output opcode, funct3, branch_taken, mem_ready,
        input  mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel,
               alu_a_pc, alu_b_imm, rf_we, wb_sel, halted, err, instret
    );

endinterface

// File: rtl/multicycle_ctrl_mem_timeout.sv
// Watchdog on the shared memory port: counts unanswered request cycles and
// flags the cycle whose increment would reach TIMEOUT.
`timescale 1ns/1ps
module mem_timeout #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

    // A completion in this cycle suppresses inc, so it always beats the timeout.
    assign expired = inc && (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I core, with a
// memory watchdog, clean/error halt and a retired-instruction counter.
`timescale 1ns/1ps
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    multicycle_ctrl_if.master bus
);

    state_t      state_q;
    state_t      state_d;
    logic        halt_err_d;
    logic        err_q;
    logic [31:0] instret_q;
    logic        waiting;
    logic        tmo_clear;
    logic        expired;
    logic        unused_funct3;

    // funct3 is carried for future decode refinement; no step depends on it yet.
    assign unused_funct3 = ^bus.funct3;

    assign waiting   = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !bus.mem_ready;
    assign tmo_clear = !waiting;

    mem_timeout #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_mem_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (tmo_clear),
        .inc     (waiting),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            err_q     <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q != ST_HALT) && (state_d == ST_HALT)) begin
                err_q <= halt_err_d;
            end
            // Every retirement updates the PC exactly once, so pc_we marks it.
            if (bus.pc_we) begin
                instret_q <= instret_q + 32'd1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        halt_err_d = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (bus.mem_ready) begin
                    state_d = ST_DECODE;
                end else if (expired) begin
                    state_d    = ST_HALT;
                    halt_err_d = 1'b1;
                end
            end
            ST_DECODE: begin
                if (!opcode_legal(bus.opcode)) begin
                    state_d    = ST_HALT;
                    halt_err_d = 1'b1;
                end else if (bus.opcode == OPC_SYSTEM) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (bus.opcode)
                    OPC_LOAD, OPC_STORE: state_d = ST_MEM;
                    OPC_BRANCH:          state_d = ST_FETCH;
                    default:             state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (bus.mem_ready) begin
                    state_d = (bus.opcode == OPC_STORE) ? ST_FETCH : ST_WB;
                end else if (expired) begin
                    state_d    = ST_HALT;
                    halt_err_d = 1'b1;
                end
            end
            ST_WB:   state_d = ST_FETCH;
            ST_HALT: state_d = ST_HALT;
            default: begin
                state_d    = ST_HALT;
                halt_err_d = 1'b1;
            end
        endcase
    end

    // Strobes are gated by rst_n so an in-flight access is dropped the moment reset lands.
    always_comb begin
        bus.mem_req      = 1'b0;
        bus.mem_we       = 1'b0;
        bus.mem_addr_sel = 1'b0;
        bus.ir_we        = 1'b0;
        bus.pc_we        = 1'b0;
        bus.pc_sel       = PCSEL_PC4;
        bus.alu_a_pc     = 1'b0;
        bus.alu_b_imm    = 1'b0;
        bus.rf_we        = 1'b0;
        bus.wb_sel       = WB_ALU;
        bus.halted       = 1'b0;
        if (rst_n) begin
            case (state_q)
                ST_FETCH: begin
                    bus.mem_req = 1'b1;
                    bus.ir_we   = bus.mem_ready;
                end
                ST_EXEC: begin
                    case (bus.opcode)
                        OPC_OPIMM, OPC_LOAD, OPC_STORE: bus.alu_b_imm = 1'b1;
                        OPC_AUIPC: begin
                            bus.alu_a_pc  = 1'b1;
                            bus.alu_b_imm = 1'b1;
                        end
                        OPC_BRANCH: begin
                            bus.pc_we  = 1'b1;
                            bus.pc_sel = bus.branch_taken ? PCSEL_BRANCH : PCSEL_PC4;
                        end
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    bus.mem_req      = 1'b1;
                    bus.mem_addr_sel = 1'b1;
                    bus.mem_we       = (bus.opcode == OPC_STORE);
                    bus.alu_b_imm    = 1'b1;
                    bus.pc_we        = bus.mem_ready && (bus.opcode == OPC_STORE);
                end
                ST_WB: begin
                    bus.rf_we = 1'b1;
                    bus.pc_we = 1'b1;
                    case (bus.opcode)
                        OPC_LOAD: bus.wb_sel = WB_LOAD;
                        OPC_LUI:  bus.wb_sel = WB_IMM;
                        OPC_JAL: begin
                            bus.wb_sel = WB_PC4;
                            bus.pc_sel = PCSEL_BRANCH;
                        end
                        OPC_JALR: begin
                            bus.wb_sel    = WB_PC4;
                            bus.pc_sel    = PCSEL_JALR;
                            bus.alu_b_imm = 1'b1;
                        end
                        default: bus.wb_sel = WB_ALU;
                    endcase
                end
                ST_HALT: bus.halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.err     = err_q;
    assign bus.instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: a driver issues instructions and
// answers memory requests, a monitor compares each retirement/halt against a per-instruction model.
`timescale 1ns/1ps
module tb_multicycle_ctrl;
    import rv_ctrl_pkg::*;

    localparam int TMO   = 4;
    localparam int NEVER = -1;

    localparam logic [6:0] RUN_OPS [9] = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                                           OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP};

    typedef struct {
        bit          is_halt;
        bit          err;
        int          cycles;
        int          ir_cycles;
        int          rf_cycles;
        int          data_cycles;
        int          we_cycles;
        int          bimm_cycles;
        int          apc_cycles;
        logic [1:0]  pc_sel;
        logic [1:0]  wb_sel;
        logic [31:0] instret_before;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] model_instret = '0;

    multicycle_ctrl_if bus();

    multicycle_ctrl #(.TIMEOUT(TMO), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Whole-instruction expectation from cycle budgets: fetch takes fw+1
    // cycles, decode/exec one each, a data access mw+1, writeback one.
    function automatic exp_t buildExpected(input logic [6:0] opc, input bit taken, input int fw,
                                           input int mw, input logic [31:0] icount);
        exp_t e;
        int   fetch_len;
        e.is_halt = 1'b0;  e.err = 1'b0;       e.cycles = 0;      e.ir_cycles = 1;
        e.rf_cycles = 0;   e.data_cycles = 0;  e.we_cycles = 0;   e.bimm_cycles = 0;
        e.apc_cycles = 0;  e.pc_sel = 2'b00;   e.wb_sel = 2'b00;  e.instret_before = icount;
        fetch_len = fw + 1;
        if (fw == NEVER) begin
            e.is_halt = 1'b1;  e.err = 1'b1;  e.ir_cycles = 0;  e.cycles = TMO + 1;
        end else if (!(opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
                                   OPC_STORE, OPC_OPIMM, OPC_OP, OPC_SYSTEM})) begin
            e.is_halt = 1'b1;  e.err = 1'b1;  e.cycles = fetch_len + 2;
        end else if (opc == OPC_SYSTEM) begin
            e.is_halt = 1'b1;  e.err = 1'b0;  e.cycles = fetch_len + 2;
        end else if (opc == OPC_BRANCH) begin
            e.cycles = fetch_len + 2;
            e.pc_sel = taken ? 2'b01 : 2'b00;
        end else if ((opc == OPC_LOAD) || (opc == OPC_STORE)) begin
            if (mw == NEVER) begin
                e.is_halt = 1'b1;  e.err = 1'b1;  e.cycles = fetch_len + TMO + 3;
            end else begin
                e.data_cycles = mw + 1;
                e.bimm_cycles = mw + 2;
                if (opc == OPC_LOAD) begin
                    e.cycles = fetch_len + mw + 4;  e.rf_cycles = 1;  e.wb_sel = 2'b01;
                end else begin
                    e.cycles = fetch_len + mw + 3;  e.we_cycles = mw + 1;
                end
            end
        end else begin
            e.cycles = fetch_len + 3;
            e.rf_cycles = 1;
            case (opc)
                OPC_LUI:   e.wb_sel = 2'b11;
                OPC_JAL:   begin e.wb_sel = 2'b10; e.pc_sel = 2'b01; end
                OPC_JALR:  begin e.wb_sel = 2'b10; e.pc_sel = 2'b10; e.bimm_cycles = 1; end
                OPC_AUIPC: begin e.bimm_cycles = 1; e.apc_cycles = 1; end
                OPC_OPIMM: e.bimm_cycles = 1;
                default:   ;
            endcase
        end
        return e;
    endfunction

    // Issue one instruction, play the memory with fw/mw wait states, and
    // return once it retires or halts.
    task automatic applyStimulus(input logic [6:0] opc, input bit taken, input int fw, input int mw);
        exp_t e;
        int   fleft;
        int   dleft;
        int   guard;
        bit   done;
        e = buildExpected(opc, taken, fw, mw, model_instret);
        if (!e.is_halt) model_instret = model_instret + 32'd1;
        exp_q.push_back(e);
        fleft = fw;  dleft = mw;  guard = 0;  done = 1'b0;
        while (!done) begin
            @(negedge clk);
            bus.opcode       = opc;
            bus.branch_taken = taken;
            bus.funct3       = 3'($urandom);
            bus.mem_ready    = 1'b0;
            if (bus.mem_req && !bus.mem_addr_sel) begin
                if (fleft == 0) bus.mem_ready = 1'b1;
                else if (fleft > 0) fleft--;
            end else if (bus.mem_req && bus.mem_addr_sel) begin
                if (dleft == 0) bus.mem_ready = 1'b1;
                else if (dleft > 0) dleft--;
            end
            #1;
            if (bus.pc_we || bus.halted) done = 1'b1;
            guard++;
            if (!done && guard > 200) begin
                tests++;
                fails++;
                $display("[TB] FAIL driver_bound: opcode %b never retired or halted within %0d cycles", opc, guard);
                done = 1'b1;
            end
        end
    endtask

    task automatic releaseReset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n         = 1'b0;
        bus.mem_ready = 1'b0;
        exp_q.delete();
        model_instret = '0;
        repeat (2) @(negedge clk);
        releaseReset();
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_mem_req"},   32'(bus.mem_req),   32'd0);
        checkOutput({tag, "_mem_we"},    32'(bus.mem_we),    32'd0);
        checkOutput({tag, "_ir_we"},     32'(bus.ir_we),     32'd0);
        checkOutput({tag, "_pc_we"},     32'(bus.pc_we),     32'd0);
        checkOutput({tag, "_rf_we"},     32'(bus.rf_we),     32'd0);
        checkOutput({tag, "_alu_b_imm"}, 32'(bus.alu_b_imm), 32'd0);
        checkOutput({tag, "_pc_sel"},    32'(bus.pc_sel),    32'd0);
        checkOutput({tag, "_wb_sel"},    32'(bus.wb_sel),    32'd0);
        checkOutput({tag, "_halted"},    32'(bus.halted),    32'd0);
        checkOutput({tag, "_err"},       32'(bus.err),       32'd0);
        checkOutput({tag, "_instret"},   bus.instret,        32'd0);
    endtask

    // Monitor: accumulates per-instruction strobe activity and scores it at each retire/halt.
    initial begin : monitor
        int   cnt, irc, rfc, dcyc, wecyc, bimm, apc;
        bit   halt_seen;
        exp_t e;
        cnt = 0; irc = 0; rfc = 0; dcyc = 0; wecyc = 0; bimm = 0; apc = 0; halt_seen = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                cnt = 0; irc = 0; rfc = 0; dcyc = 0; wecyc = 0; bimm = 0; apc = 0; halt_seen = 1'b0;
            end else if (!halt_seen) begin
                cnt++;
                if (bus.ir_we) irc++;
                if (bus.rf_we) rfc++;
                if (bus.mem_req && bus.mem_addr_sel) dcyc++;
                if (bus.mem_req && bus.mem_we) wecyc++;
                if (bus.alu_b_imm) bimm++;
                if (bus.alu_a_pc) apc++;
                if (bus.pc_we || bus.halted) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("[TB] FAIL unexpected_event: pc_we=%0b halted=%0b with nothing outstanding", bus.pc_we, bus.halted);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("event_is_halt", 32'(bus.halted), 32'(e.is_halt));
                        checkOutput("cycles", 32'(cnt), 32'(e.cycles));
                        checkOutput("ir_we_cycles", 32'(irc), 32'(e.ir_cycles));
                        checkOutput("rf_we_cycles", 32'(rfc), 32'(e.rf_cycles));
                        checkOutput("instret", bus.instret, e.instret_before);
                        if (bus.halted) begin
                            checkOutput("halt_err", 32'(bus.err), 32'(e.err));
                            checkOutput("halt_mem_req", 32'(bus.mem_req), 32'd0);
                            halt_seen = 1'b1;
                        end else begin
                            checkOutput("data_cycles", 32'(dcyc), 32'(e.data_cycles));
                            checkOutput("mem_we_cycles", 32'(wecyc), 32'(e.we_cycles));
                            checkOutput("alu_b_imm_cycles", 32'(bimm), 32'(e.bimm_cycles));
                            checkOutput("alu_a_pc_cycles", 32'(apc), 32'(e.apc_cycles));
                            checkOutput("pc_sel", 32'(bus.pc_sel), 32'(e.pc_sel));
                            checkOutput("wb_sel", 32'(bus.wb_sel), 32'(e.wb_sel));
                        end
                    end
                    cnt = 0; irc = 0; rfc = 0; dcyc = 0; wecyc = 0; bimm = 0; apc = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        fails++;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [6:0] opc;
        int         guard;
        bus.opcode = OPC_OP;  bus.funct3 = 3'd0;  bus.branch_taken = 1'b0;  bus.mem_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkIdleOutputs("reset");
        releaseReset();

        // Directed program: ADDI, LW with 3 data waits, SW, taken/not-taken BEQ, jumps, LUI.
        applyStimulus(OPC_OPIMM,  1'b0, 0, 0);
        applyStimulus(OPC_LOAD,   1'b0, 0, 3);
        applyStimulus(OPC_STORE,  1'b0, 0, 0);
        applyStimulus(OPC_BRANCH, 1'b1, 0, 0);
        applyStimulus(OPC_BRANCH, 1'b0, 0, 0);
        applyStimulus(OPC_JAL,    1'b0, 0, 0);
        applyStimulus(OPC_JALR,   1'b0, 0, 0);
        applyStimulus(OPC_LUI,    1'b0, 0, 0);
        applyStimulus(OPC_AUIPC,  1'b0, 1, 0);
        applyStimulus(OPC_OP,     1'b0, 2, 0);
        // Completion arriving on the last cycle before the watchdog fires.
        applyStimulus(OPC_OPIMM,  1'b0, TMO - 1, 0);
        applyStimulus(OPC_STORE,  1'b0, TMO - 1, TMO - 1);

        for (int i = 0; i < 60; i++) begin
            applyStimulus(RUN_OPS[$urandom_range(0, 8)], 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, TMO - 1)), int'($urandom_range(0, TMO - 1)));
        end

        // Fetch never answered: error halt, request stays dropped, instret preserved.
        applyStimulus(OPC_OP, 1'b0, NEVER, 0);
        repeat (2) @(negedge clk);
        #1;
        checkOutput("tmo_fetch_mem_req", 32'(bus.mem_req), 32'd0);
        checkOutput("tmo_fetch_halted",  32'(bus.halted),  32'd1);
        checkOutput("tmo_fetch_err",     32'(bus.err),     32'd1);
        checkOutput("tmo_fetch_instret", bus.instret,      model_instret);
        doReset();

        applyStimulus(OPC_LOAD, 1'b0, 1, NEVER);
        doReset();
        applyStimulus(OPC_SYSTEM, 1'b0, int'($urandom_range(0, TMO - 1)), 0);
        doReset();
        applyStimulus(7'b1111111, 1'b0, 0, 0);
        doReset();
        for (int i = 0; i < 4; i++) begin
            opc = 7'($urandom);
            guard = 0;
            while ((opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
                                OPC_STORE, OPC_OPIMM, OPC_OP, OPC_SYSTEM}) && guard < 50) begin
                opc = 7'($urandom);
                guard++;
            end
            applyStimulus(OPC_OPIMM, 1'b0, 0, 0);
            applyStimulus(opc, 1'b0, int'($urandom_range(0, TMO - 1)), 0);
            doReset();
        end

        // Reset landing in the middle of an unanswered load data phase.
        applyStimulus(OPC_OPIMM, 1'b0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.opcode    = OPC_LOAD;
            bus.mem_ready = bus.mem_req && !bus.mem_addr_sel;
        end
        @(negedge clk);
        bus.mem_ready = 1'b0;
        rst_n         = 1'b0;
        exp_q.delete();
        model_instret = '0;
        #1;
        checkIdleOutputs("midmem");
        @(negedge clk);
        releaseReset();

        for (int i = 0; i < 10; i++) begin
            applyStimulus(RUN_OPS[$urandom_range(0, 8)], 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, TMO - 1)), int'($urandom_range(0, TMO - 1)));
        end
        applyStimulus(OPC_SYSTEM, 1'b0, 0, 0);
        @(negedge clk);
        #1;
        checkOutput("final_instret", bus.instret, model_instret);
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
